// File: rtl/i2c_scl_sched.sv
// Bit-level I2C SCL/SDA sequencer: each command runs four equal quarter phases
// with SCL stretch support. Optional arbitration-loss abort under I2C_ARB_LOST_EN.
module i2c_scl_sched #(
  parameter int                   DIV_WIDTH    = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_QDIV = 16'd250
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] qdiv_cfg,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd,
  input  logic                 cmd_bit,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 scl_oe,
  output logic                 sda_oe,
  output logic                 rsp_valid,
  output logic                 rsp_bit,
  output logic                 busy
`ifdef I2C_ARB_LOST_EN
  ,
  output logic                 arb_lost
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} state_e;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_STOP  = 2'b11;
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] qdiv_q, qdiv_d;
  logic [1:0]           cmd_q, cmd_d;
  logic                 bit_q, bit_d;
  logic                 scl_oe_q, scl_oe_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 rsp_bit_q, rsp_bit_d;
  logic                 init_q;
  logic                 accept, last, stall, is_bit;

  // {scl_oe, sda_oe} for a given command and quarter phase
  function automatic logic [1:0] sched(input logic [1:0] c, input logic b, input logic [1:0] ph);
    logic [1:0] r;
    r = 2'b00;
    case (c)
      C_START: r = (ph == 2'd0) ? 2'b00 : (ph == 2'd3) ? 2'b11 : 2'b01;
      C_STOP:  r = (ph == 2'd0) ? 2'b11 : (ph == 2'd1) ? 2'b01 : 2'b00;
      C_WRITE: r = {(ph == 2'd0) || (ph == 2'd3), ~b};
      default: r = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
    endcase
    return r;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && init_q;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = (cnt_q == qdiv_q - ONE);
  assign is_bit    = cmd_q[1] ^ cmd_q[0];
  assign stall     = (state_q == S_RUN) && ((phase_q == 2'd1) || (phase_q == 2'd2))
                     && !scl_oe_q && !scl_in;

`ifdef I2C_ARB_LOST_EN
  logic arb_hit;
  assign arb_hit = (state_q == S_RUN) && !stall && last && !sda_in &&
                   (((cmd_q == C_WRITE) && bit_q && (phase_q == 2'd2)) ||
                    ((cmd_q == C_START) && (phase_q == 2'd0)));
  assign arb_lost = arb_hit;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    qdiv_d    = qdiv_q;
    cmd_d     = cmd_q;
    bit_d     = bit_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    rsp_bit_d = rsp_bit_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d              = S_RUN;
          phase_d              = 2'd0;
          cnt_d                = '0;
          qdiv_d               = (qdiv_cfg < TWO) ? TWO : qdiv_cfg;
          cmd_d                = cmd;
          bit_d                = cmd_bit;
          {scl_oe_d, sda_oe_d} = sched(cmd, cmd_bit, 2'd0);
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (last) begin
            cnt_d = '0;
            if ((phase_q == 2'd2) && is_bit) rsp_bit_d = sda_in;
            if (phase_q == 2'd3) begin
              state_d = S_IDLE;
            end else begin
              phase_d              = phase_q + 2'd1;
              {scl_oe_d, sda_oe_d} = sched(cmd_q, bit_q, phase_q + 2'd1);
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
`ifdef I2C_ARB_LOST_EN
        if (arb_hit) begin
          state_d  = S_ABORT;
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
        end
`endif
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      cnt_q     <= '0;
      qdiv_q    <= DEFAULT_QDIV;
      cmd_q     <= 2'b00;
      bit_q     <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      rsp_bit_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      qdiv_q    <= qdiv_d;
      cmd_q     <= cmd_d;
      bit_q     <= bit_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      rsp_bit_q <= rsp_bit_d;
      init_q    <= 1'b1;
    end
  end

  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign rsp_bit   = rsp_bit_q;
  assign busy      = (state_q == S_RUN);
  assign rsp_valid = (state_q == S_RUN) && (phase_q == 2'd3) && last && is_bit;

endmodule

// File: tb/tb_i2c_scl_sched.sv
// Self-checking bench for i2c_scl_sched: directed and random commands checked
// cycle by cycle against a phase-boundary timeline model.
module tb_i2c_scl_sched;

  logic        clock_in = 1'b0;
  logic        reset;
  logic [15:0] qdiv_cfg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic        cmd_bit;
  logic        scl_in;
  logic        sda_in;
  logic        scl_oe;
  logic        sda_oe;
  logic        rsp_valid;
  logic        rsp_bit;
  logic        busy;
`ifdef I2C_ARB_LOST_EN
  logic        arb_lost;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  i2c_scl_sched dut (
    .clock_in (clock_in),
    .reset    (reset),
    .qdiv_cfg (qdiv_cfg),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .cmd_bit  (cmd_bit),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .rsp_valid(rsp_valid),
    .rsp_bit  (rsp_bit),
    .busy     (busy)
`ifdef I2C_ARB_LOST_EN
    ,
    .arb_lost (arb_lost)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Timeline model: quarter ends at cycles e0..e3 after accept, a stretch of
  // slen cycles inside phase sp (1 or 2) lengthens that phase by slen.
  task automatic run_cmd(input logic [1:0] c, input logic b, input logic [15:0] cfg,
                         input int sp, input int off, input int slen, input int sda_fix);
    int Q, e0, e1, e2, L, ss, se, ph;
    logic [3:0] sclp, sdap;
    logic samp, isbit;
    Q  = (cfg < 16'd2) ? 2 : int'(cfg);
    e0 = Q;
    e1 = 2 * Q + ((sp == 1) ? slen : 0);
    e2 = e1 + Q + ((sp == 2) ? slen : 0);
    L  = e2 + Q;
    ss = ((sp == 1) ? Q + 1 : e1 + 1) + off;
    se = (sp == 0) ? -1 : ss + slen - 1;
    isbit = (c == 2'd1) || (c == 2'd2);
    samp  = 1'b0;
    case (c)
      2'd0:    begin sclp = 4'b1000; sdap = 4'b1110; end
      2'd1:    begin sclp = 4'b1001; sdap = {4{~b}}; end
      2'd2:    begin sclp = 4'b1001; sdap = 4'b0000; end
      default: begin sclp = 4'b0001; sdap = 4'b0011; end
    endcase

    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_bit   = b;
    qdiv_cfg  = cfg;
    scl_in    = 1'b1;
    sda_in    = 1'($urandom);
    step();
    for (int k = 1; k <= L; k++) begin
      ph = (k <= e0) ? 0 : (k <= e1) ? 1 : (k <= e2) ? 2 : 3;
      cmd_valid = 1'($urandom);
      cmd       = 2'($urandom);
      cmd_bit   = 1'($urandom);
      qdiv_cfg  = 16'($urandom_range(0, 12));
      sda_in    = (sda_fix >= 0) ? 1'(sda_fix) : 1'($urandom);
      if (k >= ss && k <= se) scl_in = 1'b0;
      else if (ph == 0 || ph == 3) scl_in = 1'($urandom);
      else scl_in = 1'b1;
      if (k == e2) samp = sda_in;
      chk("scl_oe", 32'(scl_oe), 32'(sclp[ph]));
      chk("sda_oe", 32'(sda_oe), 32'(sdap[ph]));
      chk("busy_run", 32'(busy), 32'd1);
      chk("ready_run", 32'(cmd_ready), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(k == L && isbit));
      if (k == L && isbit) chk("rsp_bit", 32'(rsp_bit), 32'(samp));
      step();
    end
    cmd_valid = 1'b0;
    scl_in    = 1'b1;
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("scl_oe_hold", 32'(scl_oe), 32'(sclp[3]));
    chk("sda_oe_hold", 32'(sda_oe), 32'(sdap[3]));
  endtask

  initial begin
    int c, b, cfg, sp, slen, off, q;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd       = 2'd0;
    cmd_bit   = 1'b0;
    qdiv_cfg  = 16'd4;
    scl_in    = 1'b1;
    sda_in    = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_scl_oe", 32'(scl_oe), 32'd0);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_bit", 32'(rsp_bit), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    reset = 1'b0;
    step();
    chk("ready_first_edge", 32'(cmd_ready), 32'd1);
    chk("no_accept_in_reset", 32'(busy), 32'd0);
    cmd_valid = 1'b0;

    run_cmd(2'd0, 1'b0, 16'd4, 0, 0, 0, -1);   // START
    run_cmd(2'd2, 1'b0, 16'd4, 0, 0, 0, 0);    // READ, SDA low
    run_cmd(2'd1, 1'b1, 16'd4, 0, 0, 0, 1);    // WRITE 1, SDA high
    run_cmd(2'd1, 1'b0, 16'd4, 1, 0, 10, -1);  // stretch in Q1
    run_cmd(2'd2, 1'b1, 16'd0, 0, 0, 0, -1);   // clamped divisor
    run_cmd(2'd3, 1'b0, 16'd1, 2, 1, 3, -1);   // STOP, stretch in Q2

    for (int i = 0; i < 40; i++) begin
      c    = $urandom_range(0, 3);
      b    = $urandom_range(0, 1);
      cfg  = $urandom_range(0, 7);
      q    = (cfg < 2) ? 2 : cfg;
      sp   = $urandom_range(0, 2);
      slen = (sp == 0) ? 0 : $urandom_range(0, 12);
      off  = $urandom_range(0, q - 1);
      run_cmd(2'(c), 1'(b), 16'(cfg), sp, off, slen, -1);
    end

    // asynchronous reset in STOP Q1
    cmd_valid = 1'b1;
    cmd       = 2'd3;
    qdiv_cfg  = 16'd4;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stop_q1_scl", 32'(scl_oe), 32'd0);
    chk("stop_q1_sda", 32'(sda_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_scl", 32'(scl_oe), 32'd0);
    chk("async_rst_sda", 32'(sda_oe), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    run_cmd(2'd2, 1'b0, 16'd3, 0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
